// File: rtl/board_manager.sv
`default_nettype none
// ============================================================================
//  Module      : board_manager
//  Description : Deals a two-row board of up to ten 4-bit digit slots from a
//                free-running 16-bit LFSR, then applies or rejects pairwise
//                merge requests until the board is empty.
//
//  Ports
//    clk          in   1   clock, rising-edge active
//    rst_n        in   1   asynchronous active-low reset
//    start        in   1   pulse: deal a new board (ignored while dealing)
//    num          in   3   active columns per row (0 -> 1, >5 -> 5)
//    merge_valid  in   1   pulse: merge request
//    src_index    in   5   bit offset of first-picked slot
//    dst_index    in   5   bit offset of second-picked slot
//    result       in   4   merged digit written to dst (0 removes the pair)
//    status       out  40  board, slot k at bits [4k+3:4k]
//    busy         out  1   dealing
//    ready        out  1   accepting merges
//    merge_ack    out  1   pulse: merge applied
//    merge_err    out  1   pulse: merge rejected
//    remaining    out  4   number of nonzero slots
//    win          out  1   board cleared
//
//  Revision    : 1.0  initial release
// ============================================================================
module board_manager #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  num,
    input  logic        merge_valid,
    input  logic [4:0]  src_index,
    input  logic [4:0]  dst_index,
    input  logic [3:0]  result,
    output logic [39:0] status,
    output logic        busy,
    output logic        ready,
    output logic        merge_ack,
    output logic        merge_err,
    output logic [3:0]  remaining,
    output logic        win
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_PLAY  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;
    localparam int         c_SLOTS = 10;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [15:0] r_lfsr;
    logic        w_fb;
    logic [39:0] r_status;
    logic [3:0]  r_cnt;
    logic [2:0]  r_num;
    logic [2:0]  w_num_eff;
    logic        r_busy;
    logic        r_ready;
    logic        r_win;
    logic        r_ack;
    logic        r_err;
    logic [3:0]  w_remaining;
    logic [3:0]  w_deal;
    logic [3:0]  w_src_val;
    logic [3:0]  w_dst_val;
    logic        w_src_act;
    logic        w_dst_act;
    logic        w_merge_ok;

    // Slot s sits in column s mod 5; it is live when that column is below n.
    function automatic logic f_active(input logic [3:0] slot, input logic [2:0] n);
        logic [3:0] col;
        col = (slot >= 4'd5) ? slot - 4'd5 : slot;
        return col < {1'b0, n};
    endfunction

    // Taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB.
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    assign w_num_eff = (num == 3'd0) ? 3'd1 : ((num > 3'd5) ? 3'd5 : num);

    // (lfsr mod 9) + 1 on a 4-bit value: 0..8 -> 1..9, 9..15 -> 1..7.
    assign w_deal = (r_lfsr[3:0] >= 4'd9) ? r_lfsr[3:0] - 4'd8 : r_lfsr[3:0] + 4'd1;

    // A 5-bit aligned offset tops out at 28, so it is always within the
    // 36-bit limit; slots 8 and 9 simply cannot be addressed by a merge.
    assign w_src_val  = r_status[src_index +: 4];
    assign w_dst_val  = r_status[dst_index +: 4];
    assign w_src_act  = f_active({1'b0, src_index[4:2]}, r_num);
    assign w_dst_act  = f_active({1'b0, dst_index[4:2]}, r_num);
    assign w_merge_ok = (src_index[1:0] == 2'b00) && (dst_index[1:0] == 2'b00)
                     && (src_index != dst_index)
                     && w_src_act && w_dst_act
                     && (w_src_val != 4'd0) && (w_dst_val != 4'd0)
                     && (result <= 4'd9);

    always_comb begin
        w_remaining = 4'd0;
        for (int k = 0; k < c_SLOTS; k++) begin
            if (r_status[4*k +: 4] != 4'd0) begin
                w_remaining = w_remaining + 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: if (start) w_next = c_FILL;
            c_FILL:         if (r_cnt == 4'd9) w_next = c_PLAY;
            c_PLAY: begin
                if (start) begin
                    w_next = c_FILL;
                end else if (w_remaining == 4'd0) begin
                    w_next = c_DONE;
                end
            end
            default:        w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_lfsr   <= SEED;
            r_status <= '0;
            r_cnt    <= 4'd0;
            r_num    <= 3'd5;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_win    <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_lfsr  <= {r_lfsr[14:0], w_fb};
            r_state <= w_next;
            r_busy  <= (w_next == c_FILL);
            r_ready <= (w_next == c_PLAY);
            r_win   <= (w_next == c_DONE);
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_num    <= w_num_eff;
                        r_cnt    <= 4'd0;
                        r_status <= '0;
                    end
                end
                c_FILL: begin
                    r_status[{r_cnt, 2'b00} +: 4] <= f_active(r_cnt, r_num) ? w_deal : 4'd0;
                    r_cnt <= r_cnt + 4'd1;
                end
                c_PLAY: begin
                    // A redeal takes precedence and silently drops any merge.
                    if (start) begin
                        r_num    <= w_num_eff;
                        r_cnt    <= 4'd0;
                        r_status <= '0;
                    end else if (merge_valid) begin
                        if (w_merge_ok) begin
                            r_status[dst_index +: 4] <= result;
                            r_status[src_index +: 4] <= 4'd0;
                            r_ack <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign status    = r_status;
    assign busy      = r_busy;
    assign ready     = r_ready;
    assign win       = r_win;
    assign merge_ack = r_ack;
    assign merge_err = r_err;
    assign remaining = w_remaining;

endmodule
`default_nettype wire

// File: tb/tb_board_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_manager
//  Description : Directed self-checking bench for board_manager: reset,
//                dealing against a reference LFSR, merges, rejections,
//                clear-to-win and start/merge priority.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_board_manager;

    localparam logic [15:0] c_SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  num;
    logic        merge_valid;
    logic [4:0]  src_index;
    logic [4:0]  dst_index;
    logic [3:0]  result;
    logic [39:0] status;
    logic        busy;
    logic        ready;
    logic        merge_ack;
    logic        merge_err;
    logic [3:0]  remaining;
    logic        win;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] m_lfsr;
    logic [39:0] exp_status;
    int          exp_rem;

    board_manager #(.SEED(c_SEED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num        (num),
        .merge_valid(merge_valid),
        .src_index  (src_index),
        .dst_index  (dst_index),
        .result     (result),
        .status     (status),
        .busy       (busy),
        .ready      (ready),
        .merge_ack  (merge_ack),
        .merge_err  (merge_err),
        .remaining  (remaining),
        .win        (win)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; the reference LFSR
    // tracks the DUT register value between edges.
    task automatic tick();
        @(posedge clk);
        if (rst_n) m_lfsr = lfsr_step(m_lfsr);
        #1;
    endtask

    // Deal a board and check it slot by slot against the reference LFSR.
    // A merge during FILL and a second start during FILL are both injected
    // and must have no effect.
    task automatic deal(input logic [2:0] n_in, input int n_eff, input bit with_merge);
        int col;
        int v;
        start = 1'b1;
        num   = n_in;
        if (with_merge) begin
            merge_valid = 1'b1;
            src_index   = 5'd4;
            dst_index   = 5'd8;
            result      = 4'd3;
        end
        tick();
        start       = 1'b0;
        merge_valid = 1'b0;
        num         = 3'd0;
        chk("deal_busy_start", busy, 1);
        chk("deal_ready_start", ready, 0);
        if (with_merge) begin
            chk("prio_ack", merge_ack, 0);
            chk("prio_err", merge_err, 0);
        end
        exp_status = '0;
        exp_rem    = 0;
        for (int k = 0; k < 10; k++) begin
            col = k % 5;
            if (col < n_eff) begin
                v = (m_lfsr[3:0] % 9) + 1;
                exp_status[4*k +: 4] = v[3:0];
                exp_rem++;
            end
            if (k == 2) begin
                merge_valid = 1'b1;
                src_index   = 5'd0;
                dst_index   = 5'd20;
                result      = 4'd1;
            end
            if (k == 5) begin
                start = 1'b1;
                num   = 3'd5;
            end
            tick();
            merge_valid = 1'b0;
            start       = 1'b0;
            num         = 3'd0;
            if (k == 2) begin
                chk("fill_merge_ack", merge_ack, 0);
                chk("fill_merge_err", merge_err, 0);
            end
            if (k < 9) chk("fill_busy", busy, 1);
        end
        chk("deal_busy_end", busy, 0);
        chk("deal_ready_end", ready, 1);
        chk("deal_status", status, exp_status);
        chk("deal_remaining", remaining, exp_rem);
    endtask

    // Issue one merge and check the pulse, the board, and that the pulse
    // lasts a single cycle.
    task automatic merge(input string tag, input logic [4:0] s, input logic [4:0] d,
                         input logic [3:0] r, input bit exp_ok);
        merge_valid = 1'b1;
        src_index   = s;
        dst_index   = d;
        result      = r;
        tick();
        merge_valid = 1'b0;
        if (exp_ok) begin
            exp_status[{d, 2'b00} >> 2 +: 4] = 4'd0;
            exp_status[d +: 4] = r;
            exp_status[s +: 4] = 4'd0;
            exp_rem = exp_rem - 1 - ((r == 4'd0) ? 1 : 0);
        end
        chk({tag, "_ack"}, merge_ack, exp_ok);
        chk({tag, "_err"}, merge_err, !exp_ok);
        chk({tag, "_status"}, status, exp_status);
        chk({tag, "_remaining"}, remaining, exp_rem);
        tick();
        chk({tag, "_pulse_end"}, {merge_ack, merge_err}, 2'b00);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        num         = 3'd0;
        merge_valid = 1'b0;
        src_index   = 5'd0;
        dst_index   = 5'd0;
        result      = 4'd0;
        m_lfsr      = c_SEED;

        tick();
        tick();
        chk("rst_status", status, 40'd0);
        chk("rst_flags", {busy, ready, win, merge_ack, merge_err}, 5'b00000);
        chk("rst_remaining", remaining, 0);

        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_flags", {busy, ready, win}, 3'b000);

        // Abort mid-FILL: outputs must clear as soon as rst_n falls.
        start = 1'b1;
        num   = 3'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("midfill_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        m_lfsr = c_SEED;
        chk("abort_status", status, 40'd0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        chk("abort_remaining", remaining, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // num=3: slots 0-2 and 5-7 live, remaining 6.
        deal(3'd3, 3, 1'b0);
        chk("deal3_rem6", remaining, 6);
        chk("deal3_inactive", {status[15:12], status[19:16], status[35:32], status[39:36]}, 16'h0);

        merge("merge_0_20", 5'd0, 5'd20, 4'd7, 1'b1);
        chk("merge_slot0", status[3:0], 0);
        chk("merge_slot5", status[23:20], 7);

        merge("rej_same", 5'd4, 5'd4, 4'd5, 1'b0);
        merge("rej_unaligned", 5'd2, 5'd8, 4'd5, 1'b0);
        merge("rej_inactive", 5'd4, 5'd12, 4'd5, 1'b0);
        merge("rej_empty_src", 5'd0, 5'd4, 4'd5, 1'b0);
        merge("rej_result10", 5'd4, 5'd8, 4'd10, 1'b0);
        chk("rej_still_ready", ready, 1);

        // Redeal from PLAY with a simultaneous merge: start wins.
        deal(3'd1, 1, 1'b1);
        chk("deal1_rem2", remaining, 2);

        merge("clear", 5'd0, 5'd20, 4'd0, 1'b1);
        chk("done_win", win, 1);
        chk("done_ready", ready, 0);
        chk("done_status", status, 40'd0);

        // Merge in DONE is ignored.
        merge_valid = 1'b1;
        src_index   = 5'd0;
        dst_index   = 5'd4;
        result      = 4'd2;
        tick();
        merge_valid = 1'b0;
        chk("done_merge_ignored", {merge_ack, merge_err, win}, 3'b001);

        // num=7 saturates to 5: all ten slots live.
        deal(3'd7, 5, 1'b0);
        chk("deal5_rem10", remaining, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_manager.md
BOARD_MANAGER -- requirements
Module: board_manager

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, the LFSR reset value; must be nonzero.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, one-cycle pulse to deal a new board.
REQ-005 SHALL have port num, input, 3, active columns per row; 0 is treated as 1, values above 5 as 5; sampled only when start is accepted.
REQ-006 SHALL have port merge_valid, input, 1, one-cycle merge request.
REQ-007 SHALL have port src_index, input, 5, bit offset of the first-picked slot.
REQ-008 SHALL have port dst_index, input, 5, bit offset of the second-picked slot.
REQ-009 SHALL have port result, input, 4, the merged digit (0-9) for dst.
REQ-010 SHALL have port status, output, 40, the board; slot k occupies bits [4k+3:4k].
REQ-011 SHALL have port busy, output, 1, high during FILL.
REQ-012 SHALL have port ready, output, 1, high in PLAY.
REQ-013 SHALL have port merge_ack, output, 1, one-cycle pulse on an applied merge.
REQ-014 SHALL have port merge_err, output, 1, one-cycle pulse on a rejected merge.
REQ-015 SHALL have port remaining, output, 4, count of nonzero slots (combinational from status).
REQ-016 SHALL have port win, output, 1, high in DONE.

Function
REQ-017 Board layout SHALL be: row 0 = slots 0-4 (offsets 0,4,...,16); row 1 = slots 5-9 (offsets 20,...,36); column = slot mod 5; a slot is active iff its column < effective num.
REQ-018 SHALL implement 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running every cycle in all states.
REQ-019 FSM SHALL have states IDLE, FILL, PLAY, DONE.
REQ-020 IDLE/DONE/PLAY + start: latch effective num, clear slot counter, enter FILL next edge; start during FILL SHALL be ignored.
REQ-021 FILL SHALL write one slot per cycle, slots 0..9 in order: active slot gets (lfsr[3:0] mod 9)+1 (range 1-9); inactive slot gets 0; after slot 9 is written, enter PLAY (10 cycles in FILL).
REQ-022 In PLAY a merge SHALL be valid iff: both indices multiples of 4 and <= 36; src != dst; both slots active; both slots nonzero.
REQ-023 Valid merge sampled at edge N SHALL, at edge N: set slot dst to result, set slot src to 0, pulse merge_ack for the following cycle.
REQ-024 result of 0 SHALL leave dst empty (pair removed); result > 9 SHALL be rejected as invalid.
REQ-025 Invalid merge SHALL leave status unchanged and pulse merge_err for one cycle.
REQ-026 merge_valid outside PLAY SHALL be ignored: no ack, no err, no change.
REQ-027 start and merge_valid in the same PLAY cycle: start wins, merge is dropped with no ack/err.
REQ-028 When remaining reaches 0 in PLAY, FSM SHALL enter DONE at the next edge; status stays all-zero.
REQ-029 busy, ready, win SHALL be registered state decodes, mutually exclusive.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, status 0, lfsr SEED, slot counter 0, busy/ready/win/merge_ack/merge_err 0, latched num 5.
REQ-031 Reset during FILL or PLAY SHALL abort the operation with no partial-board retention.

Verification
REQ-032 Reset: hold rst_n low mid-FILL -> status=0, busy=0, ready=0, remaining=0 same cycle as rst_n falls.
REQ-033 Deal: start with num=3 -> busy high exactly 10 cycles; then ready=1, slots 0-2 and 5-7 in 1-9, slots 3,4,8,9 = 0, remaining=6; match golden LFSR model from SEED.
REQ-034 Merge: in PLAY, src=0, dst=20, result=7 -> next cycle status[3:0]=0, status[23:20]=7, merge_ack=1 for one cycle, remaining decreases by 1.
REQ-035 Rejections: src=dst=4; src=2 (unaligned); dst=12 with num=3 (inactive); src on empty slot; result=10 -> each gives merge_err=1 one cycle, status unchanged.
REQ-036 Clear-to-win: num=1, merge src=0, dst=20, result=0 -> remaining=0, next cycle win=1, ready=0; start then redeals (busy=1).
REQ-037 Priority: start and merge_valid in the same PLAY cycle -> no ack/err, FILL entered, board re-dealt.
